// File: rtl/encrypt_arbiter.sv
// Two-client round-robin arbiter in front of one iterative encrypt engine.
// Clients and engine both use 4-phase req/ack handshakes; all outputs are registered.
`ifndef N_K
`define N_K 32
`endif
`ifndef N_B
`define N_B 32
`endif

module encrypt_arbiter #(
  parameter int N_K = `N_K,
  parameter int N_B = `N_B
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0,
  input  logic           req1,
  input  logic [N_K-1:0] k0,
  input  logic [N_K-1:0] k1,
  input  logic [N_B-1:0] m0,
  input  logic [N_B-1:0] m1,
  output logic           ack0,
  output logic           ack1,
  output logic [N_B-1:0] c0,
  output logic [N_B-1:0] c1,
  output logic           e_req,
  output logic [N_K-1:0] e_k,
  output logic [N_B-1:0] e_m,
  input  logic           e_ack,
  input  logic [N_B-1:0] e_c
);

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, RESP} state_t;

  state_t         state_q, state_d;
  logic           g_q, g_d;
  logic           lp_q, lp_d;
  logic [1:0]     armed_q, armed_d;
  logic [1:0]     ack_q, ack_d;
  logic           e_req_q, e_req_d;
  logic [N_K-1:0] e_k_q, e_k_d;
  logic [N_B-1:0] e_m_q, e_m_d;
  logic [N_B-1:0] c0_q, c0_d;
  logic [N_B-1:0] c1_q, c1_d;

  logic [1:0] req;
  logic [1:0] elig;
  logic       win;

  assign req  = {req1, req0};
  // A client only competes after it has been seen low since its last grant.
  assign elig = req & armed_q;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    lp_d    = lp_q;
    armed_d = armed_q | ~req;
    ack_d   = ack_q;
    e_req_d = e_req_q;
    e_k_d   = e_k_q;
    e_m_d   = e_m_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    win     = 1'b0;
    case (state_q)
      IDLE: begin
        // e_ack still high (e.g. after a mid-transaction reset) blocks any issue.
        if (!e_ack && (elig != 2'b00)) begin
          win          = (elig == 2'b11) ? ~lp_q : elig[1];
          g_d          = win;
          armed_d[win] = 1'b0;
          e_req_d      = 1'b1;
          e_k_d        = win ? k1 : k0;
          e_m_d        = win ? m1 : m0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (e_ack) begin
          if (g_q) c1_d = e_c;
          else     c0_d = e_c;
          e_req_d = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!e_ack) begin
          ack_d[g_q] = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (!req[g_q]) begin
          ack_d   = 2'b00;
          lp_d    = g_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q     <= 1'b0;
      lp_q    <= 1'b1;
      armed_q <= 2'b11;
      ack_q   <= 2'b00;
      e_req_q <= 1'b0;
      e_k_q   <= '0;
      e_m_q   <= '0;
      c0_q    <= '0;
      c1_q    <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      lp_q    <= lp_d;
      armed_q <= armed_d;
      ack_q   <= ack_d;
      e_req_q <= e_req_d;
      e_k_q   <= e_k_d;
      e_m_q   <= e_m_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
    end
  end

  assign ack0  = ack_q[0];
  assign ack1  = ack_q[1];
  assign c0    = c0_q;
  assign c1    = c1_q;
  assign e_req = e_req_q;
  assign e_k   = e_k_q;
  assign e_m   = e_m_q;

endmodule

// File: tb/tb_encrypt_arbiter.sv
// Bench for encrypt_arbiter: behavioural engine with programmable latency,
// round-robin service model, and per-scenario tasks with inline checks.
module tb_encrypt_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] k0 = '0, k1 = '0, m0 = '0, m1 = '0;
  logic        ack0, ack1;
  logic [31:0] c0, c1;
  logic        e_req;
  logic [31:0] e_k, e_m;
  logic        e_ack = 1'b0;
  logic [31:0] e_c = '0;

  int vectors = 0;
  int miscompares = 0;
  int grants = 0;

  int          eng_lat = 4;
  int          eng_cnt = 0;
  int          eng_force = 0;
  bit          use_fixed = 0;
  logic [31:0] fixed_c = '0;

  encrypt_arbiter #(.N_K(32), .N_B(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .k0(k0), .k1(k1), .m0(m0), .m1(m1),
    .ack0(ack0), .ack1(ack1), .c0(c0), .c1(c1),
    .e_req(e_req), .e_k(e_k), .e_m(e_m),
    .e_ack(e_ack), .e_c(e_c)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [31:0] k, input logic [31:0] m);
    return (k ^ {m[15:0], m[31:16]}) + 32'h9E37_79B9;
  endfunction

  // Engine: answers e_req after eng_lat cycles, releases e_ack once e_req drops.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (eng_force > 0) begin
        e_ack = 1'b1;
        eng_force--;
        eng_cnt = 0;
      end else if (e_ack) begin
        if (!e_req) e_ack = 1'b0;
      end else if (e_req) begin
        if (eng_cnt >= eng_lat) begin
          e_ack = 1'b1;
          e_c = use_fixed ? fixed_c : enc(e_k, e_m);
          eng_cnt = 0;
        end else eng_cnt++;
      end else eng_cnt = 0;
    end
  end

  // Always-on protocol checks and grant counting.
  logic        prev_req = 1'b0;
  logic [31:0] prev_k = '0, prev_m = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        vectors++;
        if (ack0 && ack1) begin
          miscompares++;
          $display("FAIL ack_onehot: ack0=%b ack1=%b, required not both 1", ack0, ack1);
        end
        vectors++;
        if (e_req && (ack0 || ack1)) begin
          miscompares++;
          $display("FAIL ereq_ack_excl: e_req=%b ack0=%b ack1=%b, required e_req=0 while ack", e_req, ack0, ack1);
        end
        if (prev_req && e_req) begin
          vectors++;
          if (e_k !== prev_k || e_m !== prev_m) begin
            miscompares++;
            $display("FAIL engine_stable: e_k=%h e_m=%h, required %h %h", e_k, e_m, prev_k, prev_m);
          end
        end
        if (e_req && !prev_req) grants++;
      end
      prev_req = rst_n ? e_req : 1'b0;
      prev_k   = e_k;
      prev_m   = e_m;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  task automatic apply_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    eng_force = 0; e_ack = 1'b0; use_fixed = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_any_ack(input int budget, output int who, output int cyc);
    who = -1; cyc = -1;
    for (int i = 0; i < budget && who < 0; i++) begin
      @(negedge clk);
      if (ack0) begin who = 0; cyc = i + 1; end
      else if (ack1) begin who = 1; cyc = i + 1; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (e_req !== 1'b0) begin miscompares++; $display("FAIL reset_ereq: got %b, required 0", e_req); end
    vectors++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b%b, required 00", ack1, ack0); end
    vectors++; if (c0 !== 32'h0 || c1 !== 32'h0) begin miscompares++; $display("FAIL reset_c: got %h %h, required 0 0", c0, c1); end
    vectors++; if (e_k !== 32'h0 || e_m !== 32'h0) begin miscompares++; $display("FAIL reset_ekm: got %h %h, required 0 0", e_k, e_m); end
    apply_reset();
  endtask

  task automatic test_single();
    int who, cyc;
    apply_reset();
    use_fixed = 1; fixed_c = 32'h0000_ABCD; eng_lat = 33;
    k0 = 32'h1; m0 = 32'h2; req0 = 1'b1;
    @(negedge clk);
    vectors++; if (e_req !== 1'b1) begin miscompares++; $display("FAIL single_ereq_rise: got %b, required 1", e_req); end
    vectors++; if (e_k !== 32'h1 || e_m !== 32'h2) begin miscompares++; $display("FAIL single_ekm: got %h %h, required 1 2", e_k, e_m); end
    wait_any_ack(100, who, cyc);
    vectors++; if (who !== 0) begin miscompares++; $display("FAIL single_ack_who: got %0d, required 0", who); end
    vectors++; if (cyc !== 35) begin miscompares++; $display("FAIL single_ack_latency: got %0d, required 35", cyc); end
    vectors++; if (c0 !== 32'h0000_ABCD || c1 !== 32'h0) begin miscompares++; $display("FAIL single_c: got %h %h, required abcd 0", c0, c1); end
    repeat (3) @(negedge clk);
    vectors++; if (ack0 !== 1'b1) begin miscompares++; $display("FAIL single_ack_hold: got %b, required 1", ack0); end
    req0 = 1'b0;
    @(negedge clk);
    vectors++; if (ack0 !== 1'b0) begin miscompares++; $display("FAIL single_ack_fall: got %b, required 0", ack0); end
    vectors++; if (c0 !== 32'h0000_ABCD) begin miscompares++; $display("FAIL single_c_held: got %h, required abcd", c0); end
    use_fixed = 0;
  endtask

  task automatic test_tie();
    int who, cyc;
    logic [31:0] ec0;
    apply_reset();
    eng_lat = $urandom_range(2, 8);
    k0 = $urandom; m0 = $urandom; k1 = $urandom; m1 = $urandom;
    req0 = 1'b1; req1 = 1'b1;
    wait_any_ack(200, who, cyc);
    vectors++; if (who !== 0) begin miscompares++; $display("FAIL tie1_first: got %0d, required 0", who); end
    ec0 = enc(k0, m0);
    vectors++; if (c0 !== ec0 || c1 !== 32'h0) begin miscompares++; $display("FAIL tie1_c: got %h %h, required %h 0", c0, c1, ec0); end
    req0 = 1'b0;
    wait_any_ack(200, who, cyc);
    vectors++; if (who !== 1) begin miscompares++; $display("FAIL tie1_second: got %0d, required 1", who); end
    vectors++; if (c1 !== enc(k1, m1) || c0 !== ec0) begin miscompares++; $display("FAIL tie1_c2: got %h %h, required %h %h", c0, c1, ec0, enc(k1, m1)); end
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    k0 = $urandom; m0 = $urandom; k1 = $urandom; m1 = $urandom;
    req0 = 1'b1; req1 = 1'b1;
    wait_any_ack(200, who, cyc);
    vectors++; if (who !== 0) begin miscompares++; $display("FAIL tie2_first: got %0d, required 0", who); end
    req0 = 1'b0;
    wait_any_ack(200, who, cyc);
    vectors++; if (who !== 1) begin miscompares++; $display("FAIL tie2_second: got %0d, required 1", who); end
    req1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int who, cyc, g0;
    apply_reset();
    eng_lat = 3;
    g0 = grants;
    for (int t = 0; t < 3; t++) begin
      k1 = $urandom; m1 = $urandom; req1 = 1'b1;
      wait_any_ack(100, who, cyc);
      vectors++; if (who !== 1 || c1 !== enc(k1, m1)) begin miscompares++; $display("FAIL b2b_txn%0d: who=%0d c1=%h, required 1 %h", t, who, c1, enc(k1, m1)); end
      req1 = 1'b0;
      @(negedge clk);
      vectors++; if (ack1 !== 1'b0) begin miscompares++; $display("FAIL b2b_ackfall%0d: got %b, required 0", t, ack1); end
    end
    vectors++; if (grants - g0 !== 3) begin miscompares++; $display("FAIL b2b_toggled_grants: got %0d, required 3", grants - g0); end
    g0 = grants;
    req1 = 1'b1;
    wait_any_ack(100, who, cyc);
    repeat (60) @(negedge clk);
    vectors++; if (ack1 !== 1'b1) begin miscompares++; $display("FAIL b2b_held_ack: got %b, required 1", ack1); end
    vectors++; if (grants - g0 !== 1) begin miscompares++; $display("FAIL b2b_held_grants: got %0d, required 1", grants - g0); end
    req1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_early_drop();
    int who, cyc, pulses, seen;
    logic [31:0] ec1;
    apply_reset();
    eng_lat = 2;
    k1 = $urandom; m1 = $urandom; req1 = 1'b1;
    wait_any_ack(100, who, cyc);
    req1 = 1'b0;
    ec1 = enc(k1, m1);
    repeat (2) @(negedge clk);
    eng_lat = 10;
    k0 = $urandom; m0 = $urandom; req0 = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (e_req) seen = 1;
    end
    vectors++; if (seen !== 1) begin miscompares++; $display("FAIL early_issue: e_req seen %0d, required 1", seen); end
    repeat (2) @(negedge clk);
    req0 = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack0) pulses++;
    end
    vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL early_ack_pulse: got %0d cycles, required 1", pulses); end
    vectors++; if (c0 !== enc(k0, m0)) begin miscompares++; $display("FAIL early_c0: got %h, required %h", c0, enc(k0, m0)); end
    vectors++; if (c1 !== ec1) begin miscompares++; $display("FAIL early_c1_kept: got %h, required %h", c1, ec1); end
  endtask

  task automatic test_reset_mid();
    int who, cyc, first_low, first_req, overlap;
    apply_reset();
    eng_lat = 20;
    k0 = $urandom; m0 = $urandom; req0 = 1'b1;
    repeat (4) @(negedge clk);
    eng_force = 5;
    rst_n = 1'b0;
    #1;
    vectors++; if (e_req !== 1'b0 || ack0 !== 1'b0) begin miscompares++; $display("FAIL rstmid_outputs: e_req=%b ack0=%b, required 0 0", e_req, ack0); end
    vectors++; if (e_k !== 32'h0 || c0 !== 32'h0) begin miscompares++; $display("FAIL rstmid_data: e_k=%h c0=%h, required 0 0", e_k, c0); end
    @(negedge clk);
    rst_n = 1'b1;
    first_low = -1; first_req = -1; overlap = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (e_req && e_ack) overlap++;
      if (!e_ack && first_low < 0) first_low = i;
      if (e_req && first_req < 0) first_req = i;
    end
    vectors++; if (overlap !== 0) begin miscompares++; $display("FAIL rstmid_issue_while_ack: got %0d cycles, required 0", overlap); end
    vectors++; if (first_low < 3 || first_req !== first_low) begin miscompares++; $display("FAIL rstmid_reissue: e_req at %0d, e_ack low at %0d, required equal and >=3", first_req, first_low); end
    wait_any_ack(100, who, cyc);
    vectors++; if (who !== 0 || c0 !== enc(k0, m0)) begin miscompares++; $display("FAIL rstmid_complete: who=%0d c0=%h, required 0 %h", who, c0, enc(k0, m0)); end
    req0 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    int who, cyc, pat, first, cli, last;
    logic [31:0] kk [2];
    logic [31:0] mm [2];
    logic [31:0] exp_c [2];
    apply_reset();
    last = 1; exp_c[0] = '0; exp_c[1] = '0;
    for (int r = 0; r < 24; r++) begin
      pat = $urandom_range(1, 3);
      eng_lat = $urandom_range(0, 12);
      for (int j = 0; j < 2; j++) begin kk[j] = $urandom; mm[j] = $urandom; end
      k0 = kk[0]; m0 = mm[0]; k1 = kk[1]; m1 = mm[1];
      req0 = pat[0]; req1 = pat[1];
      first = (pat == 3) ? 1 - last : ((pat == 2) ? 1 : 0);
      for (int s = 0; s < ((pat == 3) ? 2 : 1); s++) begin
        cli = (s == 0) ? first : 1 - first;
        wait_any_ack(300, who, cyc);
        vectors++; if (who !== cli) begin miscompares++; $display("FAIL rand%0d_winner: got %0d, required %0d", r, who, cli); end
        exp_c[cli] = enc(kk[cli], mm[cli]);
        vectors++; if (c0 !== exp_c[0] || c1 !== exp_c[1]) begin miscompares++; $display("FAIL rand%0d_c: got %h %h, required %h %h", r, c0, c1, exp_c[0], exp_c[1]); end
        if (cli == 0) req0 = 1'b0; else req1 = 1'b0;
        @(negedge clk);
        vectors++; if ((cli == 0 ? ack0 : ack1) !== 1'b0) begin miscompares++; $display("FAIL rand%0d_ackfall: got 1, required 0", r); end
        last = cli;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_early_drop();
    test_reset_mid();
    test_random();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
